// File: rtl/aes_pkg.sv
// Shared AES key-schedule types, constants and XOR-chain helpers.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    EMIT   = 2'd2
  } kx_state_e;

  // Round constants, MSB byte of the word; valid rounds are 1..10.
  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [31:0] rot_word(input logic [31:0] x);
    return {x[23:0], x[31:24]};
  endfunction

  // Forward round step; t = SubWord(RotWord(w3)) ^ Rcon[r].
  function automatic logic [127:0] fwd_xor(input logic [127:0] k,
                                           input logic [31:0]  t);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ t;
    w1 = k[95:64]  ^ w0;
    w2 = k[63:32]  ^ w1;
    w3 = k[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Backward round step; t = SubWord(RotWord(w3' ^ w2')) ^ Rcon[r].
  function automatic logic [127:0] inv_xor(input logic [127:0] k,
                                           input logic [31:0]  t);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0]   ^ k[63:32];
    w2 = k[63:32]  ^ k[95:64];
    w1 = k[95:64]  ^ k[127:96];
    w0 = k[127:96] ^ t;
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/sbox.sv
// AES forward S-box on NUM parallel bytes: GF(2^8) inverse then affine map.
module sbox #(
  parameter int NUM = 4
) (
  input  logic [8*NUM-1:0] in_i,
  output logic [8*NUM-1:0] out_o
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse; 0 maps to 0 naturally.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
    x2   = gmul(x, x);
    x3   = gmul(x2, x);
    x6   = gmul(x3, x3);
    x12  = gmul(x6, x6);
    x15  = gmul(x12, x3);
    x30  = gmul(x15, x15);
    x60  = gmul(x30, x30);
    x120 = gmul(x60, x60);
    x240 = gmul(x120, x120);
    x252 = gmul(x240, x12);
    return gmul(x252, x2);
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  for (genvar g = 0; g < NUM; g++) begin : g_byte
    assign out_o[8*g +: 8] = affine(gf_inv(in_i[8*g +: 8]));
  end

endmodule

// File: rtl/key_expansion_inv.sv
// Iterative AES-128 inverse key schedule: expands forward to round 10, then
// emits round keys 10..0 by stepping the schedule backwards per handshake.
module key_expansion_inv
  import aes_pkg::*;
#(
  parameter int LEN_KEY   = 128,
  parameter int NUM_ROUND = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LEN_KEY-1:0] key_in,
  input  logic               key_valid,
  output logic               key_ready,
  output logic [LEN_KEY-1:0] rk_out,
  output logic [3:0]         rk_index,
  output logic               rk_valid,
  input  logic               rk_ready,
  output logic               rk_last,
  output logic               busy
);

  if (LEN_KEY != 128 || NUM_ROUND != 10) begin : g_bad_param
    $error("key_expansion_inv supports only LEN_KEY=128, NUM_ROUND=10");
  end

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUND);

  kx_state_e    state_q, state_d;
  logic [127:0] kreg_q, kreg_d;
  logic [3:0]   cnt_q, cnt_d;

  logic [31:0]  sbox_in, sbox_out;
  logic [7:0]   rcon_b;
  logic [31:0]  step_t;
  logic         emit;

  assign emit = (state_q == EMIT);

  // Single shared S-box: w3 while expanding, recovered w3 (w3'^w2') while emitting.
  always_comb begin
    sbox_in = rot_word(kreg_q[31:0]);
    if (emit) sbox_in = rot_word(kreg_q[31:0] ^ kreg_q[63:32]);
  end

  sbox #(.NUM(4)) u_sbox (
    .in_i  (sbox_in),
    .out_o (sbox_out)
  );

  // Round constant for the current counter; zero outside 1..10 so no
  // out-of-range table access occurs at cnt 0.
  always_comb begin
    rcon_b = '0;
    if (cnt_q >= 4'd1 && cnt_q <= LAST_RND) rcon_b = RCON[cnt_q];
  end

  assign step_t = sbox_out ^ {rcon_b, 24'h0};

  // State, key register and round counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      kreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      kreg_q  <= kreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: load, forward expansion, then one backward step per handshake.
  always_comb begin
    state_d = state_q;
    kreg_d  = kreg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (key_valid) begin
          kreg_d  = key_in;
          cnt_d   = 4'd1;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        kreg_d = fwd_xor(kreg_q, step_t);
        if (cnt_q == LAST_RND) begin
          cnt_d   = LAST_RND;
          state_d = EMIT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      EMIT: begin
        if (rk_ready) begin
          if (cnt_q != 4'd0) begin
            kreg_d = inv_xor(kreg_q, step_t);
            cnt_d  = cnt_q - 4'd1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign key_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign rk_valid  = emit;
  assign rk_out    = emit ? kreg_q : '0;
  assign rk_index  = emit ? cnt_q : '0;
  assign rk_last   = emit && (cnt_q == 4'd0);

endmodule

// File: tb/tb_key_expansion_inv.sv
// Directed and randomized-ready checks of key_expansion_inv against a
// table-driven forward key-schedule model.
module tb_key_expansion_inv;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] key_in = '0;
  logic         key_valid = 1'b0;
  logic         key_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_index;
  logic         rk_valid;
  logic         rk_ready = 1'b0;
  logic         rk_last;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [127:0] mk  [0:10];
  logic [127:0] cap [0:10];

  logic [7:0] sb [0:255] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };
  logic [7:0] rc [1:10] = '{8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,8'h80,8'h1b,8'h36};

  localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  key_expansion_inv #(.LEN_KEY(128), .NUM_ROUND(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .rk_out    (rk_out),
    .rk_index  (rk_index),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .rk_last   (rk_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Forward FIPS-197 expansion into mk[0..10].
  task automatic build_model(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t = t ^ {rc[i/4], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) mk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic check_reset_outs(input string pfx);
    check({pfx, "_key_ready"}, 128'(key_ready), 128'd1);
    check({pfx, "_rk_valid"},  128'(rk_valid),  128'd0);
    check({pfx, "_rk_last"},   128'(rk_last),   128'd0);
    check({pfx, "_busy"},      128'(busy),      128'd0);
    check({pfx, "_rk_out"},    rk_out,          128'd0);
    check({pfx, "_rk_index"},  128'(rk_index),  128'd0);
  endtask

  // Presents a key at a negedge; returns at the negedge after acceptance.
  task automatic accept(input logic [127:0] key);
    int w = 0;
    while (!key_ready && w < 50) begin @(negedge clk); w++; end
    check("accept_wait", 128'(key_ready), 128'd1);
    key_in    = key;
    key_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    key_valid = 1'b0;
    check("accept_busy", 128'(busy), 128'd1);
  endtask

  task automatic expand_wait();
    int lat = 0;
    while (!rk_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 128'(lat), 128'd10);
  endtask

  // Consumes n_hs round keys with the given rk_ready duty (percent).
  task automatic drain(input int duty, input int n_hs);
    int idx = 10;
    int hs  = 0;
    int cyc = 0;
    logic [127:0] cur;
    while (hs < n_hs && cyc < 400) begin
      check("rk_valid",  128'(rk_valid), 128'd1);
      check("rk_index",  128'(rk_index), 128'(idx));
      check("rk_out",    rk_out, mk[idx]);
      check("rk_last",   128'(rk_last), 128'(idx == 0));
      check("key_ready_busy", 128'(key_ready), 128'd0);
      cur = rk_out;
      rk_ready = (duty >= 100) ? 1'b1 : ($urandom_range(0, 99) < duty);
      @(posedge clk);
      if (rk_ready) begin
        cap[idx] = cur;
        hs++;
        idx--;
      end
      @(negedge clk);
      cyc++;
    end
    rk_ready = 1'b0;
    check("drain_handshakes", 128'(hs), 128'(n_hs));
    if (n_hs == 11) begin
      check("done_key_ready", 128'(key_ready), 128'd1);
      check("done_rk_valid",  128'(rk_valid),  128'd0);
    end
  endtask

  task automatic full_run(input logic [127:0] key, input int duty);
    build_model(key);
    accept(key);
    expand_wait();
    drain(duty, 11);
  endtask

  initial begin
    #3;
    check_reset_outs("por");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outs("idle");

    // FIPS-197 A.1 key, no backpressure.
    full_run(KEY_A1, 100);
    check("a1_rk10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("a1_rk1",  cap[1],  128'ha0fafe1788542cb123a339392a6c7605);
    check("a1_rk0",  cap[0],  KEY_A1);

    // All-zero key.
    full_run('0, 100);
    check("zero_rk10", cap[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    check("zero_rk0",  cap[0],  128'h0);

    // Backpressure with ~30% ready.
    full_run(KEY_A1, 30);
    check("bp_rk10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Busy rejection: second key held valid from EXPAND onward.
    build_model(KEY_A1);
    accept(KEY_A1);
    key_in    = 128'h000102030405060708090a0b0c0d0e0f;
    key_valid = 1'b1;
    expand_wait();
    drain(100, 11);
    build_model(128'h000102030405060708090a0b0c0d0e0f);
    @(posedge clk);
    @(negedge clk);
    key_valid = 1'b0;
    check("second_accepted", 128'(busy), 128'd1);
    expand_wait();
    drain(100, 11);
    check("second_rk10", cap[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

    // Reset during EXPAND cycle 5.
    build_model(KEY_A1);
    accept(KEY_A1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #2;
    check_reset_outs("rst_expand");
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check_reset_outs("rst_expand_stays");

    // Reset after the index-7 handshake.
    accept(KEY_A1);
    expand_wait();
    drain(60, 4);
    rst = 1'b1;
    #2;
    check_reset_outs("rst_emit");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outs("rst_emit_idle");
    full_run(128'hffeeddccbbaa99887766554433221100, 70);

    // Random regression.
    for (int k = 0; k < 500; k++) begin
      full_run({$urandom, $urandom, $urandom, $urandom}, int'($urandom_range(20, 100)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/key_expansion_inv.md
# key_expansion_inv

Iterative AES-128 inverse key schedule for the decryption datapath. It accepts a 128-bit cipher key and runs the key schedule forward, one round per cycle, to reach round key 10. It then emits round keys 10, 9, …, 0 in that order, one per valid/ready handshake, deriving each key by stepping the schedule backwards. It sits in front of the inverse-cipher round logic and reuses the shared `sbox` module with a single 4-byte S-box instance.

## Interface
Parameters:
- `LEN_KEY`, 128: cipher key width. Only 128 is legal; elaboration fails otherwise.
- `NUM_ROUND`, 10: round count. Only 10 is legal.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `key_in`  in  128  cipher key; word w0 = `key_in[127:96]`, w3 = `key_in[31:0]`.
- `key_valid`  in  1  `key_in` is valid.
- `key_ready`  out  1  block can accept a key; high only in IDLE.
- `rk_out`  out  128  current round key, in the same word order as `key_in` (w[4r] at `[127:96]`).
- `rk_index`  out  4  round number of `rk_out`, from 10 down to 0.
- `rk_valid`  out  1  `rk_out` and `rk_index` are valid.
- `rk_ready`  in  1  consumer accepts `rk_out`.
- `rk_last`  out  1  high together with `rk_valid` when `rk_index` is 0.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- States are IDLE, EXPAND and EMIT. The registers are the 128-bit key register `kreg`, the 4-bit counter `cnt` and the state.
- Word view of `kreg`: w0..w3, with w0 in `[127:96]`.
- RotWord(x) = {x[23:0], x[31:24]}. SubWord applies the AES S-box to each byte.
- Rcon[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36, placed in the MSB byte; the other 3 bytes are 0.
- Forward step r:
  - w0' = w0 ^ SubWord(RotWord(w3)) ^ Rcon[r]
  - w1' = w1 ^ w0'
  - w2' = w2 ^ w1'
  - w3' = w3 ^ w2'
- Inverse step from round r to round r-1:
  - w3 = w3' ^ w2'
  - w2 = w2' ^ w1'
  - w1 = w1' ^ w0'
  - w0 = w0' ^ SubWord(RotWord(w3)) ^ Rcon[r]
- There is one S-box instance. Its input is muxed by state: w3 of `kreg` in EXPAND, and w3'^w2' of `kreg` in EMIT.
- IDLE:
  - `key_ready` is 1.
  - On `key_valid & key_ready`: `kreg` <= `key_in`, `cnt` <= 1, next state EXPAND.
- EXPAND:
  - Each cycle: `kreg` <= forward(`kreg`, `cnt`) and `cnt` <= `cnt` + 1.
  - On the cycle where `cnt` == 10: `cnt` <= 10 and next state EMIT.
- EMIT:
  - `rk_valid` = 1, `rk_out` = `kreg`, `rk_index` = `cnt`.
  - On `rk_valid & rk_ready` with `cnt` > 0: `kreg` <= inverse(`kreg`, `cnt`), `cnt` <= `cnt` - 1.
  - On a handshake with `cnt` == 0: next state IDLE.
  - Without a handshake, `rk_out` and `rk_index` hold stable.
- `key_valid` is ignored outside IDLE. A key presented while busy stays pending until IDLE.
- The Rcon index never goes out of range: it is 1..10 in both directions. Step-back is not evaluated at `cnt` == 0.

## Timing
- Reset values: state IDLE, `kreg` 0, `cnt` 0. Outputs: `key_ready` 1, `rk_valid` 0, `rk_last` 0, `busy` 0, `rk_out` 0, `rk_index` 0.
- An asserted `rst` forces the reset values immediately, in any state, including mid-EXPAND or mid-EMIT. A partially emitted sequence is abandoned and does not resume.
- Latency: if the key handshake occurs on edge E, `rk_valid` rises after edge E+10 with `rk_index` 10.
- With `rk_ready` held high, one key is emitted per cycle: 11 cycles for indices 10..0.
- `key_ready` rises the cycle after the index-0 handshake. Back-to-back throughput is therefore 22 cycles per key.
- All outputs are registered or decoded from state/`cnt` only. There is no combinational path from `rk_ready` or `key_valid` to any output.
- `rk_ready` may toggle arbitrarily. Each handshake advances exactly one key.

## Structure
- Package `aes_pkg` holds:
  - the state enum `kx_state_e` (IDLE, EXPAND, EMIT);
  - the `RCON` constant array with entries 1..10;
  - functions `rot_word`, `fwd_xor` and `inv_xor`, which cover the XOR chain excluding SubWord.
- One sub-module: the existing `sbox` with `NUM`=4, instantiated once.

## Test plan
- FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c, `rk_ready`=1:
  - first `rk_out` d014f9a8c9ee2589e13f0cc8b6630ca6 with `rk_index` 10, 10 cycles after acceptance;
  - `rk_index` 1 gives a0fafe1788542cb123a339392a6c7605;
  - `rk_index` 0 equals the key, with `rk_last`=1;
  - `key_ready` is 1 on the next cycle.
- All-zero key:
  - `rk_index` 10 gives b4ef5bcb3e92e21123e951cf6f8f188e;
  - `rk_index` 0 gives all zeros;
  - all 11 keys match the software model.
- Backpressure:
  - random `rk_ready` (about 30% duty) with the A.1 key;
  - `rk_out` and `rk_index` are stable while stalled;
  - exactly 11 handshakes, in order 10..0.
- Busy rejection: a second key with `key_valid` held from EXPAND onward.
  - `key_ready` stays 0 until the sequence completes;
  - the second key is accepted the cycle after the index-0 handshake;
  - the first key's outputs are uncorrupted.
- Reset mid-operation:
  - `rst` pulsed during EXPAND cycle 5, and again after the index-7 handshake;
  - all outputs return to their reset values immediately;
  - a fresh key afterwards produces a correct full sequence.
- Random regression: 500 random keys with random `rk_ready`, compared against the software key-schedule model.
